// File: rtl/rc_mesh_port.sv
`default_nettype none
// ============================================================================
//  Module      : rc_mesh_port
//  Description : Routing-computation stage for one input port of a 2D-mesh
//                wormhole router. It decodes the destination in a head flit
//                and picks a minimal output direction. The direction is either
//                deterministic XY or chosen by neighbour buffer pressure. The
//                direction is locked for the rest of the packet, and the flit
//                and direction are registered toward the switch allocator.
//                Malformed traffic is dropped and flagged with err_out.
//
//  Ports
//    rc_clk          in   clock, all state on the rising edge
//    rst             in   synchronous reset, active-high
//    data_in         in   flit from the input FIFO
//    valid_in        in   data_in valid
//    ready_out       out  stage accepts a flit this cycle
//    N/E/S/W_pressure_in in  neighbour input-buffer occupancy (0..DEPTH)
//    data_out        out  registered flit
//    direction_out   out  one-hot {E,W,S,N}; 4'b0000 = local ejection
//    valid_out       out  data_out/direction_out valid
//    rc_ready        in   allocator accepts data_out this cycle
//    err_out         out  one-cycle pulse, a flit was dropped
//
//  Revision    : 1.0  initial release
// ============================================================================
module rc_mesh_port #(
    parameter int DATASIZE = 40,
    parameter int COORD_W  = 2,
    parameter int MESH_X   = 4,
    parameter int MESH_Y   = 4,
    parameter int X_POS    = 2,
    parameter int Y_POS    = 2,
    parameter int WIDTH    = 3,
    parameter int MODE     = 1
) (
    input  logic                rc_clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] data_in,
    input  logic                valid_in,
    output logic                ready_out,
    input  logic [WIDTH:0]      N_pressure_in,
    input  logic [WIDTH:0]      E_pressure_in,
    input  logic [WIDTH:0]      S_pressure_in,
    input  logic [WIDTH:0]      W_pressure_in,
    output logic [DATASIZE-1:0] data_out,
    output logic [3:0]          direction_out,
    output logic                valid_out,
    input  logic                rc_ready,
    output logic                err_out
);

    // Flit type encodings (top two bits of the flit)
    localparam logic [1:0] c_type_body  = 2'b00;
    localparam logic [1:0] c_type_head  = 2'b01;
    localparam logic [1:0] c_type_tail  = 2'b10;

    // One-hot output directions
    localparam logic [3:0] c_dir_local = 4'b0000;
    localparam logic [3:0] c_dir_n     = 4'b0001;
    localparam logic [3:0] c_dir_s     = 4'b0010;
    localparam logic [3:0] c_dir_w     = 4'b0100;
    localparam logic [3:0] c_dir_e     = 4'b1000;

    // Geometry as 32-bit unsigned so that every comparison below is
    // unsigned and equal-width, whatever COORD_W is.
    localparam logic [31:0] c_x_pos  = X_POS;
    localparam logic [31:0] c_y_pos  = Y_POS;
    localparam logic [31:0] c_mesh_x = MESH_X;
    localparam logic [31:0] c_mesh_y = MESH_Y;
    localparam logic        c_adaptive = (MODE != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // expecting a head flit
        ST_FWD  = 2'd1,   // inside a routed packet, direction locked
        ST_DROP = 2'd2    // inside a packet with bad destination, discard to tail
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [3:0]          r_lock_dir;
    logic [DATASIZE-1:0] r_data;
    logic [3:0]          r_dir;
    logic                r_valid;
    logic                r_err;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                w_accept;
    logic [1:0]          w_type;
    logic                w_is_head;
    logic [COORD_W-1:0]  w_dest_x;
    logic [COORD_W-1:0]  w_dest_y;
    logic [31:0]         w_dest_x32;
    logic [31:0]         w_dest_y32;
    logic                w_dest_ok;
    logic [3:0]          w_x_dir;
    logic [3:0]          w_y_dir;
    logic [WIDTH:0]      w_x_press;
    logic [WIDTH:0]      w_y_press;
    logic                w_pick_y;
    logic [3:0]          w_route;

    state_t              w_state_nxt;
    logic                w_fwd;
    logic                w_err;
    logic [3:0]          w_dir_sel;
    logic [3:0]          w_lock_nxt;

    // ------------------------------------------------------------------
    // Handshake: the output register can take a new flit when it is empty
    // or being emptied this cycle. Dropped flits also use this slot, so the
    // input never stalls on a drop beyond the normal backpressure.
    // ------------------------------------------------------------------
    assign ready_out = !r_valid || rc_ready;
    assign w_accept  = valid_in && ready_out;

    // ------------------------------------------------------------------
    // Head decode
    // ------------------------------------------------------------------
    assign w_type     = data_in[DATASIZE-1 -: 2];
    assign w_is_head  = w_type[0];   // 01 head, 11 head+tail
    assign w_dest_x   = data_in[DATASIZE-3 -: COORD_W];
    assign w_dest_y   = data_in[DATASIZE-3-COORD_W -: COORD_W];
    assign w_dest_x32 = 32'(w_dest_x);
    assign w_dest_y32 = 32'(w_dest_y);
    assign w_dest_ok  = (w_dest_x32 < c_mesh_x) && (w_dest_y32 < c_mesh_y);

    // ------------------------------------------------------------------
    // Route computation. Each axis has at most one productive direction.
    // When both axes are productive, adaptive mode takes the Y direction
    // only if its neighbour is strictly less loaded. A tie goes to X, which
    // keeps the adaptive router XY-like when the load is balanced.
    // ------------------------------------------------------------------
    always_comb begin
        w_x_dir   = (w_dest_x32 > c_x_pos) ? c_dir_e : c_dir_w;
        w_x_press = (w_dest_x32 > c_x_pos) ? E_pressure_in : W_pressure_in;
        // North is decreasing Y
        w_y_dir   = (w_dest_y32 < c_y_pos) ? c_dir_n : c_dir_s;
        w_y_press = (w_dest_y32 < c_y_pos) ? N_pressure_in : S_pressure_in;
        w_pick_y  = c_adaptive && (w_y_press < w_x_press);

        if ((w_dest_x32 == c_x_pos) && (w_dest_y32 == c_y_pos)) begin
            w_route = c_dir_local;
        end else if (w_dest_x32 == c_x_pos) begin
            w_route = w_y_dir;
        end else if (w_dest_y32 == c_y_pos) begin
            w_route = w_x_dir;
        end else begin
            w_route = w_pick_y ? w_y_dir : w_x_dir;
        end
    end

    // ------------------------------------------------------------------
    // Packet FSM: next state and per-flit decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_fwd       = 1'b0;
        w_err       = 1'b0;
        w_dir_sel   = r_lock_dir;
        w_lock_nxt  = r_lock_dir;

        if (w_accept) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_is_head) begin
                        if (w_dest_ok) begin
                            w_fwd     = 1'b1;
                            w_dir_sel = w_route;
                            if (w_type == c_type_head) begin
                                w_state_nxt = ST_FWD;
                                w_lock_nxt  = w_route;
                            end
                        end else begin
                            // Bad destination. A multi-flit packet must be
                            // discarded up to its tail. A single-flit packet
                            // is already complete.
                            w_err = 1'b1;
                            if (w_type == c_type_head) begin
                                w_state_nxt = ST_DROP;
                            end
                        end
                    end else begin
                        // Body or tail without a head
                        w_err = 1'b1;
                    end
                end
                ST_FWD: begin
                    if (w_is_head) begin
                        // Stray head inside a packet. The open packet
                        // stays open.
                        w_err = 1'b1;
                    end else begin
                        w_fwd = 1'b1;
                        if (w_type == c_type_tail) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    // The error was already reported on the head.
                    if (w_type == c_type_tail) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM state and locked direction
    // ------------------------------------------------------------------
    always_ff @(posedge rc_clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_lock_dir <= c_dir_local;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_dir <= w_lock_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output register. A new flit overwrites the held flit in the same cycle
    // it transfers, so throughput stays at one flit per cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge rc_clk) begin
        if (rst) begin
            r_data  <= '0;
            r_dir   <= c_dir_local;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_fwd) begin
                r_data  <= data_in;
                r_dir   <= w_dir_sel;
                r_valid <= 1'b1;
            end else if (rc_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out      = r_data;
    assign direction_out = r_dir;
    assign valid_out     = r_valid;
    assign err_out       = r_err;

    // c_type_body documents the encoding. The decode uses only bit 0 to find
    // heads and compares against the tail code.
    logic w_unused_body;
    assign w_unused_body = ^c_type_body;

endmodule
`default_nettype wire

// File: tb/tb_rc_mesh_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rc_mesh_port
//  Description : Self-checking bench for rc_mesh_port. It has two instances,
//                one XY and one adaptive, and both are driven with the same
//                flits. A packet-level reference model predicts every output
//                each cycle. The bench runs a table of single-flit routes,
//                directed packet sequences, and a random phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rc_mesh_port;

    localparam int DS = 40;
    localparam int XP = 2;
    localparam int YP = 2;
    localparam int MX = 4;
    localparam int MY = 4;

    logic          rc_clk = 1'b0;
    logic          rst;
    logic [DS-1:0] data_in;
    logic          valid_in;
    logic          rc_ready;
    logic [3:0]    pn, pe, ps, pw;

    logic          xy_ready, ad_ready, xy_valid, ad_valid, xy_err, ad_err;
    logic [DS-1:0] xy_data, ad_data;
    logic [3:0]    xy_dir, ad_dir;

    always #5 rc_clk = ~rc_clk;

    rc_mesh_port #(.DATASIZE(DS), .COORD_W(3), .MESH_X(MX), .MESH_Y(MY),
                   .X_POS(XP), .Y_POS(YP), .WIDTH(3), .MODE(0)) dut_xy (
        .rc_clk(rc_clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_out(xy_ready), .N_pressure_in(pn), .E_pressure_in(pe),
        .S_pressure_in(ps), .W_pressure_in(pw), .data_out(xy_data),
        .direction_out(xy_dir), .valid_out(xy_valid), .rc_ready(rc_ready),
        .err_out(xy_err));

    rc_mesh_port #(.DATASIZE(DS), .COORD_W(3), .MESH_X(MX), .MESH_Y(MY),
                   .X_POS(XP), .Y_POS(YP), .WIDTH(3), .MODE(1)) dut_ad (
        .rc_clk(rc_clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ad_ready), .N_pressure_in(pn), .E_pressure_in(pe),
        .S_pressure_in(ps), .W_pressure_in(pw), .data_out(ad_data),
        .direction_out(ad_dir), .valid_out(ad_valid), .rc_ready(rc_ready),
        .err_out(ad_err));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model tracks packet context as: 0 = between packets,
    // 1 = inside a routed packet, 2 = discarding a bad packet.
    logic          m_valid, m_err;
    logic [DS-1:0] m_data;
    logic [3:0]    m_dir_xy, m_dir_ad, m_lock_xy, m_lock_ad;
    int            m_pkt;

    function automatic logic [3:0] ref_route(input int x, input int y, input int mode,
                                             input int n, input int e, input int s, input int w);
        logic [3:0] xd, yd;
        int px, py;
        if (x == XP && y == YP) return 4'b0000;
        xd = (x > XP) ? 4'b1000 : 4'b0100;
        px = (x > XP) ? e : w;
        yd = (y < YP) ? 4'b0001 : 4'b0010;
        py = (y < YP) ? n : s;
        if (x == XP) return yd;
        if (y == YP) return xd;
        if (mode == 0 || px <= py) return xd;
        return yd;
    endfunction

    function automatic logic [DS-1:0] mk(input logic [1:0] t, input int x, input int y,
                                         input logic [31:0] p);
        logic [2:0] xs, ys;
        xs = x[2:0];
        ys = y[2:0];
        return {t, xs, ys, p};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_err = 0; m_data = '0; m_dir_xy = 0; m_dir_ad = 0;
        m_lock_xy = 0; m_lock_ad = 0; m_pkt = 0;
    endtask

    // Applies the current inputs for one clock cycle. It predicts the result,
    // checks ready_out before the edge, and checks the registered outputs
    // after the edge.
    task automatic step(output bit acc);
        bit rdy, fwd, err, bad, head;
        logic [1:0] ty;
        logic [3:0] dxy, dad, lxy, lad;
        int x, y, pkt_n;
        #2;
        rdy = !m_valid || rc_ready;
        chk("ready_xy", xy_ready, rdy);
        chk("ready_ad", ad_ready, rdy);
        acc  = valid_in && rdy && !rst;
        ty   = data_in[DS-1 -: 2];
        x    = int'(data_in[DS-3 -: 3]);
        y    = int'(data_in[DS-6 -: 3]);
        bad  = (x >= MX) || (y >= MY);
        head = (ty == 2'b01) || (ty == 2'b11);
        fwd = 0; err = 0; pkt_n = m_pkt;
        dxy = m_lock_xy; dad = m_lock_ad; lxy = m_lock_xy; lad = m_lock_ad;
        if (acc) begin
            if (m_pkt == 0) begin
                if (!head) err = 1;
                else if (bad) begin
                    err = 1;
                    if (ty == 2'b01) pkt_n = 2;
                end else begin
                    fwd = 1;
                    dxy = ref_route(x, y, 0, pn, pe, ps, pw);
                    dad = ref_route(x, y, 1, pn, pe, ps, pw);
                    if (ty == 2'b01) begin pkt_n = 1; lxy = dxy; lad = dad; end
                end
            end else if (m_pkt == 1) begin
                if (head) err = 1;
                else begin
                    fwd = 1;
                    if (ty == 2'b10) pkt_n = 0;
                end
            end else begin
                if (ty == 2'b10) pkt_n = 0;
            end
        end
        @(posedge rc_clk);
        #1;
        if (rst) model_reset();
        else begin
            m_err = err;
            if (fwd) begin
                m_valid = 1; m_data = data_in; m_dir_xy = dxy; m_dir_ad = dad;
            end else if (rc_ready) m_valid = 0;
            m_pkt = pkt_n; m_lock_xy = lxy; m_lock_ad = lad;
        end
        chk("valid_xy", xy_valid, m_valid);
        chk("valid_ad", ad_valid, m_valid);
        chk("err_xy", xy_err, m_err);
        chk("err_ad", ad_err, m_err);
        chk("data_xy", xy_data, m_data);
        chk("data_ad", ad_data, m_data);
        chk("dir_xy", xy_dir, m_dir_xy);
        chk("dir_ad", ad_dir, m_dir_ad);
    endtask

    task automatic send(input logic [DS-1:0] d);
        bit acc;
        data_in = d; valid_in = 1; acc = 0;
        for (int n = 0; n < 8 && !acc; n++) step(acc);
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout: flit %h not accepted within 8 cycles", d);
        end
        valid_in = 0;
    endtask

    task automatic idle(input int n);
        bit acc;
        valid_in = 0; rc_ready = 1;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    typedef struct {
        int x, y;
        logic [3:0] pn, pe, ps, pw, exp_xy, exp_ad;
    } vec_t;
    vec_t tbl[11];

    initial begin
        bit acc;
        tbl[0]  = '{2, 2, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 4'b0000};
        tbl[1]  = '{0, 3, 4'd0, 4'd0, 4'd4, 4'd1, 4'b0100, 4'b0100};
        tbl[2]  = '{3, 0, 4'd2, 4'd5, 4'd0, 4'd0, 4'b1000, 4'b0001};
        tbl[3]  = '{3, 0, 4'd3, 4'd3, 4'd0, 4'd0, 4'b1000, 4'b1000};
        tbl[4]  = '{2, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0001, 4'b0001};
        tbl[5]  = '{2, 3, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0010, 4'b0010};
        tbl[6]  = '{3, 2, 4'd0, 4'd0, 4'd0, 4'd0, 4'b1000, 4'b1000};
        tbl[7]  = '{1, 2, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0100, 4'b0100};
        tbl[8]  = '{1, 1, 4'd0, 4'd0, 4'd0, 4'd8, 4'b0100, 4'b0001};
        tbl[9]  = '{3, 3, 4'd0, 4'd0, 4'd8, 4'd0, 4'b1000, 4'b1000};
        tbl[10] = '{0, 3, 4'd0, 4'd0, 4'd2, 4'd5, 4'b0100, 4'b0010};

        rst = 1; valid_in = 0; rc_ready = 1; data_in = '0;
        pn = 0; pe = 0; ps = 0; pw = 0;
        @(posedge rc_clk); #1;
        model_reset();
        step(acc);   // reset state checked against model values
        chk("reset_valid", xy_valid, 1'b0);
        chk("reset_dir", ad_dir, 4'b0000);
        rst = 0;

        // Single-flit packets, one per table entry
        for (int i = 0; i < 11; i++) begin
            pn = tbl[i].pn; pe = tbl[i].pe; ps = tbl[i].ps; pw = tbl[i].pw;
            send(mk(2'b11, tbl[i].x, tbl[i].y, 32'(i)));
            chk("tbl_dir_xy", xy_dir, tbl[i].exp_xy);
            chk("tbl_dir_ad", ad_dir, tbl[i].exp_ad);
            chk("tbl_valid", xy_valid, 1'b1);
        end
        idle(1);
        chk("ht_drained", xy_valid, 1'b0);

        // Three-flit packet going west
        pn = 0; pe = 0; ps = 0; pw = 0;
        send(mk(2'b01, 0, 3, 32'hA0));
        chk("t1_head_dir", xy_dir, 4'b0100);
        send(mk(2'b00, 0, 0, 32'hA1));
        chk("t1_body_dir", xy_dir, 4'b0100);
        chk("t1_body_data", xy_data, mk(2'b00, 0, 0, 32'hA1));
        send(mk(2'b10, 0, 0, 32'hA2));
        chk("t1_tail_dir", ad_dir, 4'b0100);

        // Adaptive route stays locked after the pressures change
        pn = 2; pe = 5;
        send(mk(2'b01, 3, 0, 32'hB0));
        chk("lock_head", ad_dir, 4'b0001);
        pn = 8; pe = 0;
        send(mk(2'b00, 7, 7, 32'hB1));
        chk("lock_body", ad_dir, 4'b0001);
        send(mk(2'b10, 0, 0, 32'hB2));
        chk("lock_tail", ad_dir, 4'b0001);
        pn = 0;

        // Backpressure with the source continuously valid
        idle(1);
        rc_ready = 0; valid_in = 1; data_in = mk(2'b01, 2, 0, 32'hC0);
        step(acc);
        chk("t4_first_acc", acc, 1'b1);
        data_in = mk(2'b00, 0, 0, 32'hC1);
        for (int i = 0; i < 3; i++) begin
            step(acc);
            chk("t4_ready_low", xy_ready, 1'b0);
            chk("t4_data_hold", xy_data, mk(2'b01, 2, 0, 32'hC0));
        end
        rc_ready = 1;
        step(acc);
        chk("t4_body_after", xy_data, mk(2'b00, 0, 0, 32'hC1));
        send(mk(2'b10, 0, 0, 32'hC2));
        idle(1);

        // Head with an off-mesh destination, followed by the rest of its packet
        send(mk(2'b01, 4, 1, 32'hD0));
        chk("t5_err_pulse", xy_err, 1'b1);
        chk("t5_no_valid", xy_valid, 1'b0);
        send(mk(2'b00, 0, 0, 32'hD1));
        chk("t5_err_once", xy_err, 1'b0);
        send(mk(2'b00, 0, 0, 32'hD2));
        send(mk(2'b10, 0, 0, 32'hD3));
        chk("t5_tail_drop", ad_valid, 1'b0);
        send(mk(2'b11, 2, 3, 32'hD4));
        chk("t5_recover", xy_dir, 4'b0010);
        chk("t5_recover_v", xy_valid, 1'b1);

        // Reset in the middle of a packet
        send(mk(2'b01, 3, 3, 32'hE0));
        send(mk(2'b00, 0, 0, 32'hE1));
        rst = 1; valid_in = 0;
        step(acc);
        chk("t6_rst_valid", xy_valid, 1'b0);
        rst = 0;
        send(mk(2'b00, 0, 0, 32'hE2));
        chk("t6_orphan_err", ad_err, 1'b1);
        chk("t6_orphan_drop", ad_valid, 1'b0);
        idle(1);

        // Random traffic checked against the model
        for (int i = 0; i < 500; i++) begin
            logic [1:0] t;
            t = 2'($urandom_range(0, 3));
            data_in  = mk(t, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), $urandom);
            valid_in = ($urandom_range(0, 3) != 0);
            rc_ready = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 99) == 0);
            pn = 4'($urandom_range(0, 8)); pe = 4'($urandom_range(0, 8));
            ps = 4'($urandom_range(0, 8)); pw = 4'($urandom_range(0, 8));
            step(acc);
        end
        rst = 0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
